// File: rtl/serial_sort_array.sv
// serial_sort_array: insertion-sort array of DEPTH cells. Words are inserted
// one per cycle into their sorted position (stable for equal values), then
// drained from cell 0 in order after a one-cycle drain request.
//
// Ports:
//   clk       - single clock, rising edge
//   reset     - synchronous, active-high reset
//   in_valid  - in_data offered for insertion
//   in_data   - word to insert
//   in_ready  - insertion accepted this cycle
//   drain     - one-cycle request to start clocking out sorted data
//   out_valid - out_data holds the next sorted word
//   out_data  - head cell (cell 0) contents
//   out_ready - consumer takes out_data this cycle
//   count     - number of occupied cells
//
// Configuration macro SORT_DESCENDING_EN: when defined the order is
// descending with all-zeros fill; otherwise ascending with all-ones fill.
module serial_sort_array #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         in_ready,
  input  logic                         drain,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

`ifdef SORT_DESCENDING_EN
  localparam logic [DATA_WIDTH-1:0] Fill = '0;
`else
  localparam logic [DATA_WIDTH-1:0] Fill = '1;
`endif

  typedef enum logic {StLoad, StDrain} state_e;

  state_e                  r_state;
  state_e                  w_state_next;
  logic                    w_push;
  logic                    w_pop;

  logic [DATA_WIDTH-1:0]   r_data [DEPTH];
  logic [DEPTH-1:0]        r_occ;
  logic [CW-1:0]           r_count;

  // w_ge[i]: cell i lies at or above the insertion point. Because occupied
  // cells are sorted and contiguous from cell 0, this vector is monotone.
  logic [DEPTH-1:0]        w_ge;
  logic [DEPTH-1:0]        w_prev_ge;
  logic [DEPTH-1:0]        w_prev_occ;
  logic [DATA_WIDTH-1:0]   w_prev_data [DEPTH];
  logic [DEPTH-1:0]        w_next_occ;
  logic [DATA_WIDTH-1:0]   w_next_data [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
`ifdef SORT_DESCENDING_EN
    assign w_ge[g] = !r_occ[g] || (r_data[g] < in_data);
`else
    assign w_ge[g] = !r_occ[g] || (r_data[g] > in_data);
`endif

    if (g == 0) begin : g_first
      assign w_prev_ge[g]   = 1'b0;
      assign w_prev_occ[g]  = 1'b1;
      assign w_prev_data[g] = Fill;
    end else begin : g_inner
      assign w_prev_ge[g]   = w_ge[g-1];
      assign w_prev_occ[g]  = r_occ[g-1];
      assign w_prev_data[g] = r_data[g-1];
    end

    if (g == DEPTH - 1) begin : g_top
      assign w_next_occ[g]  = 1'b0;
      assign w_next_data[g] = Fill;
    end else begin : g_below
      assign w_next_occ[g]  = r_occ[g+1];
      assign w_next_data[g] = r_data[g+1];
    end
  end

  assign in_ready  = (r_state == StLoad) && (r_count < CW'(DEPTH)) && !drain;
  assign out_valid = (r_state == StDrain);
  assign out_data  = r_data[0];
  assign count     = r_count;

  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    unique case (r_state)
      StLoad: begin
        if (drain && (r_count != '0)) begin
          w_state_next = StDrain;
        end else if (in_valid && in_ready) begin
          w_push = 1'b1;
        end
      end
      StDrain: begin
        if (out_ready) begin
          w_pop = 1'b1;
          if (r_count == CW'(1)) begin
            w_state_next = StLoad;
          end
        end
      end
      default: w_state_next = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StLoad;
      r_count <= '0;
      r_occ   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= Fill;
      end
    end else begin
      r_state <= w_state_next;
      if (w_push) begin
        r_count <= r_count + CW'(1);
        for (int i = 0; i < DEPTH; i++) begin
          if (w_ge[i]) begin
            // Insertion point takes the new word; cells above shift up.
            r_data[i] <= w_prev_ge[i] ? w_prev_data[i] : in_data;
            r_occ[i]  <= w_prev_occ[i];
          end
        end
      end else if (w_pop) begin
        r_count <= r_count - CW'(1);
        for (int i = 0; i < DEPTH; i++) begin
          r_data[i] <= w_next_data[i];
          r_occ[i]  <= w_next_occ[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_sort_array.sv
// Testbench for serial_sort_array: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the sorted contents.
module tb_serial_sort_array;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

`ifdef SORT_DESCENDING_EN
  localparam bit Desc = 1'b1;
  localparam logic [DW-1:0] Fill = '0;
`else
  localparam bit Desc = 1'b0;
  localparam logic [DW-1:0] Fill = '1;
`endif

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          drain;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [CW-1:0] count;

  int n_checks;
  int n_errors;

  // Reference model: sorted queue plus a drain-mode flag.
  int  m_q[$];
  bit  m_drain;
  int  popped[$];

  serial_sort_array #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .drain    (drain),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Stable insertion: before the first element that strictly follows v.
  function automatic void model_insert(input int v);
    int pos;
    pos = m_q.size();
    for (int i = 0; i < m_q.size(); i++) begin
      if ((!Desc && m_q[i] > v) || (Desc && m_q[i] < v)) begin
        pos = i;
        break;
      end
    end
    m_q.insert(pos, v);
  endfunction

  // One clock cycle: apply inputs, check outputs, advance the model.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic dr,
                       input logic ordy, input logic rst);
    bit exp_rdy;
    int exp_head;
    in_valid  = v;
    in_data   = d;
    drain     = dr;
    out_ready = ordy;
    reset     = rst;
    #2;
    exp_rdy  = !m_drain && (m_q.size() < DEPTH) && !dr;
    exp_head = (m_q.size() > 0) ? m_q[0] : int'(Fill);
    check("in_ready", int'(in_ready), int'(exp_rdy));
    check("out_valid", int'(out_valid), int'(m_drain));
    check("out_data", int'(out_data), exp_head);
    check("count", int'(count), m_q.size());
    if (rst) begin
      m_q.delete();
      m_drain = 1'b0;
    end else if (!m_drain) begin
      if (dr && m_q.size() > 0) m_drain = 1'b1;
      else if (v && exp_rdy) model_insert(int'(d));
    end else if (ordy) begin
      popped.push_back(m_q.pop_front());
      if (m_q.size() == 0) m_drain = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ins(input logic [DW-1:0] d);
    cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  // Drain until the model reports LOAD again, bounded.
  task automatic drain_all(input bit toggle);
    int guard;
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    guard = 0;
    while (m_drain && guard < 100) begin
      cycle(1'b0, '0, 1'b0, toggle ? (guard % 2 == 1) : 1'b1, 1'b0);
      guard++;
    end
    check("drain_done", int'(m_drain), 0);
  endtask

  initial begin
    int exp_list[4];
    n_checks = 0;
    n_errors = 0;
    m_drain  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    drain    = 1'b0;
    out_ready = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("reset_fill", int'(out_data), int'(Fill));
    idle();

    // Insertion order
    ins(5); ins(3); ins(9); ins(1);
    popped.delete();
    drain_all(1'b0);
    if (Desc) exp_list = '{9, 5, 3, 1};
    else      exp_list = '{1, 3, 5, 9};
    check("order_len", popped.size(), 4);
    for (int i = 0; i < 4 && i < popped.size(); i++) check("order_val", popped[i], exp_list[i]);
    idle();

    // Fill to full, then offered word must be refused
    for (int i = 7; i >= 0; i--) ins(DW'(i));
    ins(42);
    check("full_count", int'(count), DEPTH);
    popped.delete();
    drain_all(1'b0);
    check("full_len", popped.size(), DEPTH);
    for (int i = 0; i < popped.size(); i++) check("full_no42", int'(popped[i] == 42), 0);

    // Duplicates with backpressure
    ins(4); ins(4); ins(2);
    drain_all(1'b1);

    // Drain while empty is ignored
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle();

    // Drain together with valid input at count 2
    ins(7); ins(6);
    cycle(1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
    check("drain_wins", int'(count), 2);
    drain_all(1'b0);

    // Reset mid-drain after 2 of 5 pops
    ins(10); ins(20); ins(30); ins(40); ins(50);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'd3, 1'b1, 1'b1, 1'b1);
    check("rst_drain_fill", int'(out_data), int'(Fill));
    idle();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      cycle(1'($urandom_range(0, 1)), DW'($urandom_range(0, 15)),
            ($urandom_range(0, 11) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 299) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_sort_array.md
SERIAL_SORT_ARRAY -- requirements
Module: serial_sort_array

Interface
REQ-001 Parameter DATA_WIDTH, default 8, sets the width of each sorted word.
REQ-002 Parameter DEPTH, default 8, sets the number of sorting cells (minimum 2).
REQ-003 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  the value on in_data is offered for insertion.
REQ-006 in_data  input  DATA_WIDTH  word to insert.
REQ-007 in_ready  output  1  the array accepts in_data this cycle.
REQ-008 drain  input  1  one-cycle request to begin clocking out sorted data.
REQ-009 out_valid  output  1  out_data holds the next sorted word.
REQ-010 out_data  output  DATA_WIDTH  head cell (cell 0) contents.
REQ-011 out_ready  input  1  consumer takes out_data this cycle.
REQ-012 count  output  $clog2(DEPTH+1)  number of occupied cells.

Function
REQ-013 Array SHALL hold DEPTH cells, each with a data register and an EMPTY/OCCUPIED flag; occupied cells SHALL always form a contiguous run from cell 0, sorted ascending.
REQ-014 Controller SHALL have two states: LOAD and DRAIN.
REQ-015 LOAD: in_ready SHALL equal (count < DEPTH) && !drain.
REQ-016 Accepted word (in_valid && in_ready) SHALL be inserted in one cycle. Position: the lowest-indexed occupied cell whose value is strictly greater than in_data, or the first empty cell if no such cell exists. Cells from that position upward SHALL shift one place toward higher indices, and count SHALL increment.
REQ-017 Equal values SHALL insert after existing equal values, so the sort is stable.
REQ-018 drain in LOAD with count > 0 SHALL move to DRAIN on the next edge; input is not accepted in that cycle.
REQ-019 drain in LOAD with count == 0 SHALL be ignored; the state remains LOAD.
REQ-020 DRAIN: in_ready SHALL be 0, out_valid SHALL be 1, and out_data SHALL be cell 0.
REQ-021 Pop (out_valid && out_ready) in DRAIN SHALL shift every cell down one place and decrement count. The top cell SHALL become EMPTY and take the fill value.
REQ-022 A pop that makes count 0 SHALL return the state to LOAD on the same edge; out_valid SHALL be 0 in the following cycle.
REQ-023 In LOAD, out_valid SHALL be 0 and out_data SHALL still show cell 0.
REQ-024 If out_ready is low in DRAIN, all cells SHALL hold.
REQ-025 drain asserted in DRAIN SHALL have no effect.
REQ-026 Full (count == DEPTH): in_ready SHALL be 0 and offered data SHALL be neither accepted nor lost into the array.
REQ-027 Empty cells SHALL hold the fill value: all-ones in ascending mode.
REQ-028 Latency: a word accepted on edge N SHALL be visible in its sorted position after edge N. The first out_valid SHALL occur the cycle after the drain edge.

Reset
REQ-029 reset SHALL override all other inputs on the rising edge, including mid-insertion and mid-drain.
REQ-030 Reset values: state LOAD; all cells EMPTY holding the fill value; count 0; out_valid 0; out_data equal to the fill value; in_ready 1 once reset is released.

Configuration
REQ-031 Macro SORT_DESCENDING_EN:
- Defined: order is descending. The insertion test becomes "strictly less than". The fill value becomes all-zeros.
- Undefined: ascending order with all-ones fill, as above.

Verification
REQ-032 Insertion order: DEPTH=8, insert 5,3,9,1 then drain with out_ready=1 -> out_data 1,3,5,9 on consecutive cycles; count goes 4,3,2,1,0; then back in LOAD with out_valid=0.
REQ-033 Fill to full: insert 8 words 7..0, then offer 42 -> in_ready=0, count=8; drain yields 0..7 and 42 never appears.
REQ-034 Stability and backpressure: insert 4,4,2 (tag duplicates via a DATA_WIDTH=9 bench field), drain while toggling out_ready -> out_data 2,4a,4b, holding value whenever out_ready=0.
REQ-035 Edge cases:
- drain with count=0 -> state stays LOAD, out_valid=0.
- drain together with in_valid=1, count=2 -> input not accepted, DRAIN entered.
REQ-036 Reset mid-drain: after 2 of 5 pops, assert reset -> next cycle count=0, out_valid=0, out_data=0xFF, in_ready=1.
REQ-037 SORT_DESCENDING_EN defined: insert 5,3,9,1 -> drain yields 9,5,3,1; empty fill 0x00.
